step_idle_monitor: RTL and testbench
====================================

// Module: step_idle_monitor
// PURPOSE
//  Per-channel step-activity watchdog between the command block's step outputs and its req_shutdown input.
//  Counts clk cycles since the last step-level change on each channel and flags channels idle for
//  TIMEOUT_CYCLES. Once armed (e.g. by an endstop), it latches a shutdown request when a watched channel idles.
//  Replaces the ad-hoc watcher logic in the top level and exports idle/alert/trip status for LED debug.
// PARAMETERS
//  NCH            6                 number of step channels monitored
//  HZ             48000000          clk frequency in Hz
//  TIMEOUT_CYCLES HZ*10             idle cycles before a channel counts as idle (>=2)
//  CNT_BITS       29                idle counter width; must satisfy 2**CNT_BITS > TIMEOUT_CYCLES
//  WATCH_MASK     6'b100000         channels that may trip shutdown (bit i = channel i)
// PORTS
//  clk        in   1    system clock
//  rst_n      in   1    synchronous reset, active low
//  step       in   NCH  step levels, clk-domain (no sync)
//  arm_req    in   1    async level, active high; requests ARMED
//  disarm     in   1    1-cycle pulse: ARMED -> DISARMED
//  clear      in   1    1-cycle pulse: TRIPPED -> DISARMED
//  idle       out  NCH  level: channel counter == TIMEOUT_CYCLES
//  alert      out  NCH  1-cycle pulse when counter first reaches TIMEOUT_CYCLES
//  shutdown   out  1    registered; high only in TRIPPED
//  trip_ch    out  NCH  latched idle&WATCH_MASK at trip instant; 0 outside TRIPPED
//  state      out  2    0=DISARMED 1=ARMED 2=TRIPPED
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): counters 0, prev_step 0, arm sync 0, state DISARMED,
//   idle/alert/shutdown/trip_ch 0. Reset mid-trip drops shutdown the following edge.
//  arm_req through 2-FF synchroniser -> arm_s (2 cycles latency).
//  toggle[i] = step[i] != prev_step[i]; prev_step <= step each cycle. Both edges count.
//  Counter i: toggle -> 0; else if != TIMEOUT_CYCLES -> +1; else hold (saturate, never wraps).
//  Toggle wins over reaching timeout in the same cycle: counter resets, no alert.
//  idle[i] combinational from counter. alert[i] registered: set 1 cycle when counter transitions
//   TIMEOUT_CYCLES-1 -> TIMEOUT_CYCLES.
//  Counters run in every state; on DISARMED->ARMED all counters load 0 (no instant trip on stale idle).
//  FSM:
//   DISARMED: arm_s=1 -> ARMED. clear/disarm ignored.
//   ARMED: |(idle & WATCH_MASK) -> TRIPPED, trip_ch <= idle & WATCH_MASK; else disarm -> DISARMED.
//          Trip has priority over disarm in the same cycle.
//   TRIPPED: shutdown=1, trip_ch held; clear -> DISARMED (trip_ch <= 0). disarm, arm_s ignored.
//          clear with arm_s=1 still goes DISARMED; re-arm evaluated next cycle.
//  Latency: toggle sampled at edge k -> shutdown high after edge k+TIMEOUT_CYCLES+1 (if ARMED and no
//   further toggles). Idle unwatched channels raise idle/alert only, never shutdown.
//  arm_req held high does not re-arm automatically after TRIPPED except via clear.
// TESTING (bench overrides TIMEOUT_CYCLES=100, NCH=6, WATCH_MASK=6'b100000)
//  1 Reset, no stimulus, arm_req=0 for 300 cycles -> idle=6'h3F from cycle ~101, alert pulse once
//    per channel, shutdown=0, state=0.
//  2 arm_req=1, step[5] toggles every 50 cycles for 1000 cycles -> state=1, shutdown stays 0, idle[5]=0.
//  3 From ARMED stop toggling step[5] (last toggle sampled edge k) -> shutdown=1 exactly after edge
//    k+101, trip_ch=6'b100000, state=2; step[0..4] idle never trip alone.
//  4 In TRIPPED pulse disarm -> no change; pulse clear -> state=0, trip_ch=0, shutdown=0 next edge;
//    arm_req still 1 -> state=1 two-cycle-later with counters at 0, no immediate re-trip.
//  5 Toggle step[5] in the same cycle its counter would reach 100 -> counter 0, no alert, no trip;
//    disarm coinciding with trip cycle -> TRIPPED wins.
//  6 Assert rst_n=0 for 1 cycle while TRIPPED -> all outputs 0, state=0 after that edge.

Source files
------------

// File: rtl/step_idle_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : step_idle_monitor
//  Description : Per-channel step-activity watchdog. Counts clk cycles since
//                the last step-level change on each channel, flags channels
//                that have been idle for TIMEOUT_CYCLES and, once armed,
//                latches a shutdown request when a watched channel idles.
//                Exports idle/alert/trip status for LED debug.
//  Revision    : 1.0 - initial release
// ============================================================================
module step_idle_monitor #(
    parameter int              NCH            = 6,
    parameter int              HZ             = 48000000,
    parameter int              TIMEOUT_CYCLES = HZ * 10,
    parameter int              CNT_BITS       = 29,
    parameter logic [NCH-1:0]  WATCH_MASK     = 6'b100000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NCH-1:0]  step,
    input  logic            arm_req,
    input  logic            disarm,
    input  logic            clear,
    output logic [NCH-1:0]  idle,
    output logic [NCH-1:0]  alert,
    output logic            shutdown,
    output logic [NCH-1:0]  trip_ch,
    output logic [1:0]      state
);

    localparam logic [CNT_BITS-1:0] TIMEOUT_CNT = CNT_BITS'(TIMEOUT_CYCLES);
    localparam logic [CNT_BITS-1:0] TIMEOUT_M1  = CNT_BITS'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        TRIPPED  = 2'd2
    } state_t;

    state_t          cur_state;
    state_t          nxt_state;
    logic [NCH-1:0]  trip_nxt;
    logic [NCH-1:0]  prev_step;
    logic [NCH-1:0]  toggle;
    logic [NCH-1:0]  watched_idle;
    logic            arm_meta;
    logic            arm_s;
    logic            arm_load;

    // Previous step levels for edge detection and 2-FF synchroniser for arm_req
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_step <= '0;
            arm_meta  <= 1'b0;
            arm_s     <= 1'b0;
        end else begin
            prev_step <= step;
            arm_meta  <= arm_req;
            arm_s     <= arm_meta;
        end
    end

    // Any level change (rising or falling) counts as step activity
    assign toggle       = step ^ prev_step;
    assign watched_idle = idle & WATCH_MASK;

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            logic [CNT_BITS-1:0] cnt;
            logic                alert_r;

            // Saturating idle counter; activity or arming restarts it, and the
            // alert fires only on the genuine TIMEOUT-1 -> TIMEOUT step
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt     <= '0;
                    alert_r <= 1'b0;
                end else begin
                    alert_r <= (cnt == TIMEOUT_M1) && !toggle[i] && !arm_load;
                    if (toggle[i] || arm_load) begin
                        cnt <= '0;
                    end else if (cnt != TIMEOUT_CNT) begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end

            assign idle[i]  = (cnt == TIMEOUT_CNT);
            assign alert[i] = alert_r;
        end
    endgenerate

    // Next-state logic; arming clears all counters so stale idle cannot trip
    always_comb begin
        nxt_state = cur_state;
        trip_nxt  = trip_ch;
        arm_load  = 1'b0;
        case (cur_state)
            DISARMED: begin
                if (arm_s) begin
                    nxt_state = ARMED;
                    arm_load  = 1'b1;
                end
            end
            ARMED: begin
                if (|watched_idle) begin
                    nxt_state = TRIPPED;
                    trip_nxt  = watched_idle;
                end else if (disarm) begin
                    nxt_state = DISARMED;
                end
            end
            TRIPPED: begin
                if (clear) begin
                    nxt_state = DISARMED;
                    trip_nxt  = '0;
                end
            end
            default: begin
                nxt_state = DISARMED;
                trip_nxt  = '0;
            end
        endcase
    end

    // State register with registered shutdown and latched trip channels
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state <= DISARMED;
            trip_ch   <= '0;
            shutdown  <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            trip_ch   <= trip_nxt;
            shutdown  <= (nxt_state == TRIPPED);
        end
    end

    assign state = cur_state;

endmodule
`default_nettype wire

// File: tb/tb_step_idle_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_step_idle_monitor
//  Description : Self-checking bench for step_idle_monitor with a short
//                timeout; expected outputs are queued per cycle as stimulus
//                is driven and compared after each clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_step_idle_monitor;

    logic        clk;
    logic        rst_n;
    logic [5:0]  step;
    logic        arm_req;
    logic        disarm;
    logic        clear;
    logic [5:0]  idle;
    logic [5:0]  alert;
    logic        shutdown;
    logic [5:0]  trip_ch;
    logic [1:0]  state;

    typedef struct {
        string       tag;
        logic [1:0]  st;
        logic        sd;
        logic [5:0]  tc;
        logic [5:0]  idl;
        logic [5:0]  alr;
        logic [5:0]  msk;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    step_idle_monitor #(
        .NCH            (6),
        .TIMEOUT_CYCLES (100),
        .WATCH_MASK     (6'b100000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .step     (step),
        .arm_req  (arm_req),
        .disarm   (disarm),
        .clear    (clear),
        .idle     (idle),
        .alert    (alert),
        .shutdown (shutdown),
        .trip_ch  (trip_ch),
        .state    (state)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; step = '0; arm_req = 1'b0; disarm = 1'b0; clear = 1'b0;
        sb.push_back('{"reset", 2'd0, 1'b0, 6'h00, 6'h00, 6'h00, 6'h3F});
        tick(); tick();
        e = sb.pop_front();
        n_checks += 5;
        if (state !== e.st) begin n_fail++; $display("FAIL %s state got %0d want %0d", e.tag, state, e.st); end
        if (shutdown !== e.sd) begin n_fail++; $display("FAIL %s shutdown got %b want %b", e.tag, shutdown, e.sd); end
        if (trip_ch !== e.tc) begin n_fail++; $display("FAIL %s trip_ch got %b want %b", e.tag, trip_ch, e.tc); end
        if ((idle & e.msk) !== e.idl) begin n_fail++; $display("FAIL %s idle got %b want %b", e.tag, idle, e.idl); end
        if ((alert & e.msk) !== e.alr) begin n_fail++; $display("FAIL %s alert got %b want %b", e.tag, alert, e.alr); end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_timeout();
        int pulses [6];
        for (int i = 0; i < 6; i++) pulses[i] = 0;
        for (int c = 1; c <= 300; c++) begin
            sb.push_back('{"idle_timeout", 2'd0, 1'b0, 6'h00,
                           (c >= 100) ? 6'h3F : 6'h00, (c == 100) ? 6'h3F : 6'h00, 6'h3F});
            tick();
            e = sb.pop_front();
            n_checks += 5;
            if (state !== e.st) begin n_fail++; $display("FAIL %s c=%0d state got %0d want %0d", e.tag, c, state, e.st); end
            if (shutdown !== e.sd) begin n_fail++; $display("FAIL %s c=%0d shutdown got %b want %b", e.tag, c, shutdown, e.sd); end
            if (trip_ch !== e.tc) begin n_fail++; $display("FAIL %s c=%0d trip_ch got %b want %b", e.tag, c, trip_ch, e.tc); end
            if ((idle & e.msk) !== e.idl) begin n_fail++; $display("FAIL %s c=%0d idle got %b want %b", e.tag, c, idle, e.idl); end
            if ((alert & e.msk) !== e.alr) begin n_fail++; $display("FAIL %s c=%0d alert got %b want %b", e.tag, c, alert, e.alr); end
            for (int i = 0; i < 6; i++) if (alert[i] === 1'b1) pulses[i]++;
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (pulses[i] != 1) begin n_fail++; $display("FAIL alert_once ch%0d got %0d pulses want 1", i, pulses[i]); end
        end
    endtask

    task automatic test_arm_activity();
        arm_req = 1'b1;
        for (int c = 1; c <= 1000; c++) begin
            if (c % 50 == 10) step[5] = ~step[5];
            sb.push_back('{"arm_activity", (c < 3) ? 2'd0 : 2'd1, 1'b0, 6'h00,
                           (c < 3) ? 6'h3F : ((c >= 103) ? 6'h1F : 6'h00),
                           (c == 103) ? 6'h1F : 6'h00, 6'h3F});
            tick();
            e = sb.pop_front();
            n_checks += 5;
            if (state !== e.st) begin n_fail++; $display("FAIL %s c=%0d state got %0d want %0d", e.tag, c, state, e.st); end
            if (shutdown !== e.sd) begin n_fail++; $display("FAIL %s c=%0d shutdown got %b want %b", e.tag, c, shutdown, e.sd); end
            if (trip_ch !== e.tc) begin n_fail++; $display("FAIL %s c=%0d trip_ch got %b want %b", e.tag, c, trip_ch, e.tc); end
            if ((idle & e.msk) !== e.idl) begin n_fail++; $display("FAIL %s c=%0d idle got %b want %b", e.tag, c, idle, e.idl); end
            if ((alert & e.msk) !== e.alr) begin n_fail++; $display("FAIL %s c=%0d alert got %b want %b", e.tag, c, alert, e.alr); end
        end
    endtask

    task automatic test_trip_latency();
        step[5] = ~step[5];
        for (int j = 0; j <= 101; j++) begin
            sb.push_back('{"trip_latency", (j <= 100) ? 2'd1 : 2'd2, (j >= 101),
                           (j >= 101) ? 6'h20 : 6'h00,
                           (j >= 100) ? 6'h3F : 6'h1F, (j == 100) ? 6'h20 : 6'h00, 6'h3F});
            tick();
            e = sb.pop_front();
            n_checks += 5;
            if (state !== e.st) begin n_fail++; $display("FAIL %s j=%0d state got %0d want %0d", e.tag, j, state, e.st); end
            if (shutdown !== e.sd) begin n_fail++; $display("FAIL %s j=%0d shutdown got %b want %b", e.tag, j, shutdown, e.sd); end
            if (trip_ch !== e.tc) begin n_fail++; $display("FAIL %s j=%0d trip_ch got %b want %b", e.tag, j, trip_ch, e.tc); end
            if ((idle & e.msk) !== e.idl) begin n_fail++; $display("FAIL %s j=%0d idle got %b want %b", e.tag, j, idle, e.idl); end
            if ((alert & e.msk) !== e.alr) begin n_fail++; $display("FAIL %s j=%0d alert got %b want %b", e.tag, j, alert, e.alr); end
        end
    endtask

    task automatic test_tripped_controls();
        for (int j = 0; j < 23; j++) begin
            disarm = (j == 0);
            clear  = (j == 1);
            if (j == 0)
                sb.push_back('{"tripped_disarm", 2'd2, 1'b1, 6'h20, 6'h3F, 6'h00, 6'h3F});
            else if (j == 1)
                sb.push_back('{"tripped_clear", 2'd0, 1'b0, 6'h00, 6'h3F, 6'h00, 6'h3F});
            else
                sb.push_back('{"rearm", 2'd1, 1'b0, 6'h00, 6'h00, 6'h00, 6'h3F});
            tick();
            disarm = 1'b0;
            clear  = 1'b0;
            e = sb.pop_front();
            n_checks += 5;
            if (state !== e.st) begin n_fail++; $display("FAIL %s j=%0d state got %0d want %0d", e.tag, j, state, e.st); end
            if (shutdown !== e.sd) begin n_fail++; $display("FAIL %s j=%0d shutdown got %b want %b", e.tag, j, shutdown, e.sd); end
            if (trip_ch !== e.tc) begin n_fail++; $display("FAIL %s j=%0d trip_ch got %b want %b", e.tag, j, trip_ch, e.tc); end
            if ((idle & e.msk) !== e.idl) begin n_fail++; $display("FAIL %s j=%0d idle got %b want %b", e.tag, j, idle, e.idl); end
            if ((alert & e.msk) !== e.alr) begin n_fail++; $display("FAIL %s j=%0d alert got %b want %b", e.tag, j, alert, e.alr); end
        end
    endtask

    task automatic test_toggle_at_timeout();
        for (int j = 0; j <= 201; j++) begin
            if (j == 0 || j == 100) step[5] = ~step[5];
            disarm = (j == 201);
            sb.push_back('{"toggle_timeout", (j == 201) ? 2'd2 : 2'd1, (j == 201),
                           (j == 201) ? 6'h20 : 6'h00,
                           (j >= 200) ? 6'h20 : 6'h00, (j == 200) ? 6'h20 : 6'h00, 6'h20});
            tick();
            disarm = 1'b0;
            e = sb.pop_front();
            n_checks += 5;
            if (state !== e.st) begin n_fail++; $display("FAIL %s j=%0d state got %0d want %0d", e.tag, j, state, e.st); end
            if (shutdown !== e.sd) begin n_fail++; $display("FAIL %s j=%0d shutdown got %b want %b", e.tag, j, shutdown, e.sd); end
            if (trip_ch !== e.tc) begin n_fail++; $display("FAIL %s j=%0d trip_ch got %b want %b", e.tag, j, trip_ch, e.tc); end
            if ((idle & e.msk) !== e.idl) begin n_fail++; $display("FAIL %s j=%0d idle got %b want %b", e.tag, j, idle, e.idl); end
            if ((alert & e.msk) !== e.alr) begin n_fail++; $display("FAIL %s j=%0d alert got %b want %b", e.tag, j, alert, e.alr); end
        end
    endtask

    task automatic test_reset_in_trip();
        rst_n = 1'b0;
        for (int j = 0; j <= 3; j++) begin
            sb.push_back('{"reset_in_trip", (j == 3) ? 2'd1 : 2'd0, 1'b0, 6'h00, 6'h00, 6'h00, 6'h3F});
            tick();
            rst_n = 1'b1;
            e = sb.pop_front();
            n_checks += 5;
            if (state !== e.st) begin n_fail++; $display("FAIL %s j=%0d state got %0d want %0d", e.tag, j, state, e.st); end
            if (shutdown !== e.sd) begin n_fail++; $display("FAIL %s j=%0d shutdown got %b want %b", e.tag, j, shutdown, e.sd); end
            if (trip_ch !== e.tc) begin n_fail++; $display("FAIL %s j=%0d trip_ch got %b want %b", e.tag, j, trip_ch, e.tc); end
            if ((idle & e.msk) !== e.idl) begin n_fail++; $display("FAIL %s j=%0d idle got %b want %b", e.tag, j, idle, e.idl); end
            if ((alert & e.msk) !== e.alr) begin n_fail++; $display("FAIL %s j=%0d alert got %b want %b", e.tag, j, alert, e.alr); end
        end
        arm_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_timeout();
        test_arm_activity();
        test_trip_latency();
        test_tripped_controls();
        test_toggle_at_timeout();
        test_reset_in_trip();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
